// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller.
//
// Produces the stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM
// registers, the EX-stage operand forwarding selects, a sticky data-bus
// timeout flag and a saturating count of stalled cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rs1_id, rs2_id      source registers of the instruction in ID
//   rs1_ex, rs2_ex      source registers of the instruction in EX
//   rd_ex, ex_is_load   destination / load flag of the instruction in EX
//   rd_mem, mem_reg_write  destination / write enable in MEM
//   rd_wb,  wb_reg_write   destination / write enable in WB
//   branch_taken_ex     branch/jump in EX redirects the PC this cycle
//   mem_req, mem_ready  data-bus request from MEM / completion strobe
//   stall_*, flush_*    pipeline register controls (stall beats flush downstream)
//   fwd_a, fwd_b        EX operand select: 00 regfile, 01 MEM, 10 WB
//   mem_timeout         sticky: a data-bus wait hit MEM_TIMEOUT cycles
//   stall_count         saturating count of cycles with stall_pc high

// One forwarding lane: picks the youngest in-flight writer of rs_ex.
module hazard_fwd_lane #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] rd_wb_i,
  input  logic                  wb_reg_write_i,
  output logic [1:0]            fwd_o
);
  logic mem_hit, wb_hit;

  // x0 is hardwired zero, so a write to it is never a real producer.
  assign mem_hit = mem_reg_write_i && (rd_mem_i != '0) && (rd_mem_i == rs_ex_i);
  assign wb_hit  = wb_reg_write_i  && (rd_wb_i  != '0) && (rd_wb_i  == rs_ex_i);

  // MEM holds the more recent value, so it wins over WB.
  always_comb begin
    fwd_o = 2'b00;
    if (mem_hit)     fwd_o = 2'b01;
    else if (wb_hit) fwd_o = 2'b10;
  end
endmodule

module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken_ex,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  stall_id_ex,
  output logic                  flush_id_ex,
  output logic                  stall_ex_mem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int NUM_LANES = 2;
  // wait_cnt must reach MEM_TIMEOUT-1; keep at least one bit when disabled.
  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_LAST =
    WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH_PEND} state_e;

  state_e            state_q, state_d;
  logic              pend_flush_q, pend_flush_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic stall_all, flush_all, lu_stall;
  logic load_use, timeout_hit;

  assign load_use = ex_is_load && (rd_ex != '0) &&
                    ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  // wait_cnt counts wait cycles already spent, including the RUN cycle that
  // first saw the bus busy, so a timeout stalls exactly MEM_TIMEOUT cycles.
  assign timeout_hit = TO_EN && (wait_cnt_q >= TO_LAST);

  always_comb begin
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_all     = 1'b0;
    flush_all     = 1'b0;
    lu_stall      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall_all    = 1'b1;
          state_d      = MEM_WAIT;
          // A redirect seen while frozen must be replayed after the wait.
          pend_flush_d = branch_taken_ex;
          wait_cnt_d   = WCNT_W'(1);
        end else if (branch_taken_ex) begin
          // The flush kills the ID instruction, so any load-use is moot.
          flush_all = 1'b1;
        end else if (load_use) begin
          lu_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Stalls stay up in the completion cycle so MEM captures its data.
        stall_all    = 1'b1;
        pend_flush_d = pend_flush_q | branch_taken_ex;
        wait_cnt_d   = wait_cnt_q + WCNT_W'(1);
        if (mem_ready || timeout_hit) begin
          if (!mem_ready) mem_timeout_d = 1'b1;
          state_d      = (pend_flush_q | branch_taken_ex) ? FLUSH_PEND : RUN;
          pend_flush_d = 1'b0;
          wait_cnt_d   = '0;
        end
      end
      FLUSH_PEND: begin
        flush_all    = 1'b1;
        pend_flush_d = 1'b0;
        state_d      = RUN;
      end
      default: begin
        state_d      = RUN;
        pend_flush_d = 1'b0;
        wait_cnt_d   = '0;
      end
    endcase
  end

  // Controls are forced quiet while reset is held, independent of state.
  assign stall_pc     = rst & (stall_all | lu_stall);
  assign stall_if_id  = rst & (stall_all | lu_stall);
  assign stall_id_ex  = rst & stall_all;
  assign stall_ex_mem = rst & stall_all;
  assign flush_if_id  = rst & flush_all;
  // Load-use: the bubble goes into ID/EX while the load moves on to MEM.
  assign flush_id_ex  = rst & (flush_all | lu_stall);

  assign stall_count_d = (stall_pc && !(&stall_count_q)) ?
                         stall_count_q + CNT_W'(1) : stall_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      pend_flush_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_flush_q  <= pend_flush_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

  // Forwarding: one lane per EX source operand (lane 0 = rs1, lane 1 = rs2).
  logic [NUM_LANES-1:0][REG_ADDR_W-1:0] rs_ex_v;
  logic [NUM_LANES-1:0][1:0]            fwd_v;

  assign rs_ex_v = {rs2_ex, rs1_ex};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_fwd
    hazard_fwd_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
      .rs_ex_i        (rs_ex_v[g]),
      .rd_mem_i       (rd_mem),
      .mem_reg_write_i(mem_reg_write),
      .rd_wb_i        (rd_wb),
      .wb_reg_write_i (wb_reg_write),
      .fwd_o          (fwd_v[g])
    );
  end

  assign fwd_a = rst ? fwd_v[0] : 2'b00;
  assign fwd_b = rst ? fwd_v[1] : 2'b00;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 6;
  localparam int TO = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk, rst;
  logic [RW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          ex_is_load, mem_reg_write, wb_reg_write;
  logic          branch_taken_ex, mem_req, mem_ready;
  logic          stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem;
  logic [1:0]    fwd_a, fwd_b;
  logic          mem_timeout;
  logic [CW-1:0] stall_count;

  hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .ex_is_load(ex_is_load),
    .rd_mem(rd_mem), .mem_reg_write(mem_reg_write),
    .rd_wb(rd_wb), .wb_reg_write(wb_reg_write),
    .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex), .stall_ex_mem(stall_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: wait length so far, owed flush, sticky flag, counter.
  int m_wait;     // stall cycles spent in current bus wait (0 = not waiting)
  bit m_owe;      // a taken branch was seen during the current wait
  bit m_fnext;    // this cycle must replay the owed flush
  bit m_to;
  int m_cnt;

  logic e_spc, e_sifid, e_fifid, e_sidex, e_fidex, e_sexmem;
  logic [1:0] e_fa, e_fb;

  always_comb begin
    e_spc = 0; e_sifid = 0; e_fifid = 0; e_sidex = 0; e_fidex = 0; e_sexmem = 0;
    e_fa = 2'b00; e_fb = 2'b00;
    if (rst) begin
      if (m_fnext) begin
        e_fifid = 1; e_fidex = 1;
      end else if (m_wait > 0 || (mem_req && !mem_ready)) begin
        e_spc = 1; e_sifid = 1; e_sidex = 1; e_sexmem = 1;
      end else if (branch_taken_ex) begin
        e_fifid = 1; e_fidex = 1;
      end else if (ex_is_load && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id)) begin
        e_spc = 1; e_sifid = 1; e_fidex = 1;
      end
      if (mem_reg_write && rd_mem != 0 && rd_mem == rs1_ex)     e_fa = 2'b01;
      else if (wb_reg_write && rd_wb != 0 && rd_wb == rs1_ex)   e_fa = 2'b10;
      if (mem_reg_write && rd_mem != 0 && rd_mem == rs2_ex)     e_fb = 2'b01;
      else if (wb_reg_write && rd_wb != 0 && rd_wb == rs2_ex)   e_fb = 2'b10;
    end
  end

  bit done_rdy, owe_now;
  int n_now;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait <= 0; m_owe <= 0; m_fnext <= 0; m_to <= 0; m_cnt <= 0;
    end else begin
      if (e_spc && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_fnext) begin
        m_fnext <= 0;
      end else if (m_wait > 0 || (mem_req && !mem_ready)) begin
        done_rdy = (m_wait > 0) && mem_ready;
        n_now    = m_wait + 1;
        owe_now  = m_owe | branch_taken_ex;
        if (done_rdy || n_now >= TO) begin
          if (!done_rdy) m_to <= 1;
          m_fnext <= owe_now; m_owe <= 0; m_wait <= 0;
        end else begin
          m_wait <= n_now; m_owe <= owe_now;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("stall_pc", stall_pc, e_spc);
    chk("stall_if_id", stall_if_id, e_sifid);
    chk("flush_if_id", flush_if_id, e_fifid);
    chk("stall_id_ex", stall_id_ex, e_sidex);
    chk("flush_id_ex", flush_id_ex, e_fidex);
    chk("stall_ex_mem", stall_ex_mem, e_sexmem);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_count", stall_count, m_cnt);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    ex_is_load = 0; mem_reg_write = 0; wb_reg_write = 0;
    branch_taken_ex = 0; mem_req = 0; mem_ready = 0;
  endtask

  int rdy_pct, req_pct;

  initial begin
    idle_inputs();
    rst = 0;
    rd_mem = 7; rs1_ex = 7; mem_reg_write = 1; mem_req = 1;
    #12;
    chk("rst_stall_count", stall_count, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    chk("rst_stall_pc", stall_pc, 0);
    chk("rst_fwd_a", fwd_a, 0);
    idle_inputs();
    rst = 1;
    cyc();

    // Load-use on rs1: one stall cycle, then the bubble has moved the load on.
    ex_is_load = 1; rd_ex = 5; rs1_id = 5;
    @(negedge clk);
    chk("lu_stall_pc", stall_pc, 1);
    chk("lu_stall_if_id", stall_if_id, 1);
    chk("lu_flush_id_ex", flush_id_ex, 1);
    chk("lu_stall_id_ex", stall_id_ex, 0);
    cyc();
    ex_is_load = 0; rd_ex = 0;
    @(negedge clk);
    chk("lu_after_stall_pc", stall_pc, 0);
    chk("lu_count", stall_count, 1);
    cyc();

    // Load to x0 never stalls; branch beats load-use.
    ex_is_load = 1; rd_ex = 0; rs1_id = 0;
    @(negedge clk);
    chk("x0_load_stall_pc", stall_pc, 0);
    cyc();
    rd_ex = 5; rs1_id = 5; branch_taken_ex = 1;
    @(negedge clk);
    chk("br_lu_flush_if_id", flush_if_id, 1);
    chk("br_lu_flush_id_ex", flush_id_ex, 1);
    chk("br_lu_stall_pc", stall_pc, 0);
    cyc();
    idle_inputs();

    // Bus busy 3 cycles, ready on the 4th: four stall cycles.
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      chk("wait_stall", stall_pc, 1);
      chk("wait_stall_ex_mem", stall_ex_mem, 1);
      cyc();
    end
    mem_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("wait_done_stall", stall_pc, 0);
    chk("wait_count", stall_count, 5);
    cyc();

    // Branch during the wait is deferred to the cycle after completion.
    mem_req = 1;
    @(negedge clk); chk("defer_stall0", stall_pc, 1);
    cyc();
    branch_taken_ex = 1;
    @(negedge clk); chk("defer_noflush1", flush_if_id, 0);
    cyc();
    branch_taken_ex = 0; mem_ready = 1;
    @(negedge clk);
    chk("defer_noflush2", flush_if_id, 0);
    chk("defer_stall2", stall_pc, 1);
    cyc();
    mem_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("defer_flush_if_id", flush_if_id, 1);
    chk("defer_flush_id_ex", flush_id_ex, 1);
    chk("defer_flush_stall", stall_pc, 0);
    cyc();
    @(negedge clk);
    chk("defer_flush_once", flush_if_id, 0);
    chk("defer_count", stall_count, 8);
    cyc();

    // Bus never answers: exactly TO stall cycles, then sticky timeout.
    mem_req = 1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_stall", stall_pc, 1);
      if (i == TO - 1) chk("to_flag_before", mem_timeout, 0);
      cyc();
    end
    mem_req = 0;
    @(negedge clk);
    chk("to_exit_stall", stall_pc, 0);
    chk("to_flag", mem_timeout, 1);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("to_flag_sticky", mem_timeout, 1);
    chk("to_count", stall_count, 16);
    cyc();

    // Forwarding priority and x0.
    rd_mem = 7; rd_wb = 7; mem_reg_write = 1; wb_reg_write = 1; rs1_ex = 7; rs2_ex = 3;
    #1; chk("fwd_mem", fwd_a, 2'b01); chk("fwd_b_none", fwd_b, 2'b00);
    mem_reg_write = 0;
    #1; chk("fwd_wb", fwd_a, 2'b10);
    mem_reg_write = 1; rd_mem = 0; rd_wb = 0; rs1_ex = 0;
    #1; chk("fwd_x0", fwd_a, 2'b00);
    rd_wb = 3; rs2_ex = 3;
    #1; chk("fwd_b_wb", fwd_b, 2'b10);
    cyc();
    idle_inputs();

    // Reset in the middle of a wait with a flush owed.
    mem_req = 1;
    cyc();
    branch_taken_ex = 1;
    cyc();
    #2 rst = 0;
    #1;
    chk("mrst_stall_pc", stall_pc, 0);
    chk("mrst_stall_id_ex", stall_id_ex, 0);
    chk("mrst_count", stall_count, 0);
    cyc();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    chk("mrst_no_stall", stall_pc, 0);
    chk("mrst_no_flush", flush_if_id, 0);
    cyc();

    // Randomised traffic, checked every cycle by the model compare.
    rdy_pct = 40; req_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(2))
          0: rdy_pct = 5;
          1: rdy_pct = 40;
          default: rdy_pct = 90;
        endcase
        req_pct = 10 + 10 * $urandom_range(5);
      end
      rs1_id = RW'($urandom_range(3)); rs2_id = RW'($urandom_range(3));
      rs1_ex = RW'($urandom_range(3)); rs2_ex = RW'($urandom_range(3));
      rd_ex  = RW'($urandom_range(3)); rd_mem = RW'($urandom_range(3));
      rd_wb  = RW'($urandom_range(3));
      ex_is_load      = ($urandom_range(99) < 40);
      mem_reg_write   = ($urandom_range(99) < 60);
      wb_reg_write    = ($urandom_range(99) < 60);
      branch_taken_ex = ($urandom_range(99) < 15);
      mem_req         = ($urandom_range(99) < req_pct);
      mem_ready       = ($urandom_range(99) < rdy_pct);
      if ($urandom_range(399) == 0) rst = 0;
      else rst = 1;
      cyc();
    end
    rst = 1;
    idle_inputs();
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller that generates the stall and flush controls consumed by the stall/flush pipeline registers. Stall has priority over flush in those registers; a flush loads NOP 32'h00000013.
Detects load-use hazards, taken branches/jumps resolved in EX, and data-memory/UART wait states. Also drives EX-stage forwarding selects and a stall-cycle performance counter.
Sits in the core top level between the decode/execute/memory stages and the IF/ID and ID/EX registers.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, stall counter width
MEM_TIMEOUT, 1024, max consecutive wait cycles before abort (0 = no timeout)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
rs1_id  input  REG_ADDR_W  rs1 of instruction in ID
rs2_id  input  REG_ADDR_W  rs2 of instruction in ID
rs1_ex  input  REG_ADDR_W  rs1 of instruction in EX
rs2_ex  input  REG_ADDR_W  rs2 of instruction in EX
rd_ex  input  REG_ADDR_W  destination of instruction in EX
ex_is_load  input  1  EX instruction is a load
rd_mem  input  REG_ADDR_W  destination in MEM
mem_reg_write  input  1  MEM instruction writes rd
rd_wb  input  REG_ADDR_W  destination in WB
wb_reg_write  input  1  WB instruction writes rd
branch_taken_ex  input  1  branch/jump in EX redirects PC this cycle
mem_req  input  1  MEM stage issuing data-bus access
mem_ready  input  1  data bus completes access this cycle
stall_pc  output  1  hold PC
stall_if_id  output  1  hold IF/ID register
flush_if_id  output  1  load NOP into IF/ID
stall_id_ex  output  1  hold ID/EX register
flush_id_ex  output  1  load NOP into ID/EX
stall_ex_mem  output  1  hold EX/MEM register
fwd_a  output  2  rs1 operand select in EX: 00 regfile, 01 MEM, 10 WB
fwd_b  output  2  rs2 operand select in EX, same encoding
mem_timeout  output  1  sticky wait-state timeout flag
stall_count  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, async): state=RUN, pend_flush=0, wait_cnt=0, stall_count=0, mem_timeout=0.
- While rst=0, all stall/flush outputs are 0 and fwd_a=fwd_b=00.
- Stall/flush/fwd outputs are combinational from the current state and inputs (zero latency). state, pend_flush, wait_cnt, mem_timeout and stall_count are registered.
- FSM states: RUN, MEM_WAIT, FLUSH_PEND.
- RUN, priority order:
  - mem_req && !mem_ready: assert all four stall outputs; next state MEM_WAIT. If branch_taken_ex is high in this cycle, set pend_flush=1.
  - Else branch_taken_ex: flush_if_id=1, flush_id_ex=1, no stalls. This suppresses any concurrent load-use stall.
  - Else load-use: ex_is_load && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id). Assert stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly one cycle; the bubble advances the load.
  - Otherwise no stall and no flush.
- MEM_WAIT:
  - All four stalls asserted; branch_taken_ex ORs into pend_flush; wait_cnt increments.
  - On mem_ready: if pend_flush, next state FLUSH_PEND, else RUN. Stalls still asserted in the mem_ready cycle, so the MEM stage captures its data before advancing.
  - Timeout: MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT-1 without mem_ready. Set mem_timeout=1 (sticky until reset) and take the same exit as mem_ready.
  - wait_cnt clears on exit.
- FLUSH_PEND: one cycle with flush_if_id=1, flush_id_ex=1, pend_flush cleared, no stalls; next state RUN.
- Forwarding:
  - fwd_a=01 if mem_reg_write && rd_mem!=0 && rd_mem==rs1_ex.
  - Else fwd_a=10 if wb_reg_write && rd_wb!=0 && rd_wb==rs1_ex.
  - Else fwd_a=00. fwd_b is identical using rs2_ex.
  - MEM has priority over WB; x0 is never forwarded.
- stall_count increments by 1 in every cycle with stall_pc=1 and saturates at all-ones.
- Reset asserted mid-wait or mid-stall: immediate return to RUN, pending flush discarded.

Test Plan:
- Load x5 in EX, ID reads rs1=5 -> 1 cycle stall_pc=stall_if_id=flush_id_ex=1, then 0; stall_count=1.
- Load with rd=x0, ID rs1=0 -> no stall; branch_taken_ex concurrent with load-use -> flush_if_id=flush_id_ex=1, stall_pc=0.
- mem_req=1, mem_ready low 3 cycles then high -> stalls high 4 cycles, drop the next cycle; stall_count=4.
- branch_taken_ex=1 during MEM_WAIT -> no flush while waiting; flush_if_id=flush_id_ex=1 for the one cycle after the mem_ready cycle.
- MEM_TIMEOUT=8, mem_ready never high -> stalls for 8 cycles, mem_timeout=1 and stays 1; FSM back to RUN.
- rd_mem=rd_wb=7 both writing, rs1_ex=7 -> fwd_a=01. Clear mem_reg_write -> fwd_a=10. rd=0 -> fwd_a=00.
- Assert rst mid-MEM_WAIT -> outputs 0 immediately, stall_count=0.
